// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types for the Ethernet receive frame buffer: the MAC-side bus
// record, the frame-length type, the largest legal frame byte count and the
// write/read FSM state encodings.
package eth_rx_frame_buffer_pkg;

    localparam int FRAME_LEN_W     = 11;
    localparam int MAX_FRAME_BYTES = 2047;

    typedef logic [FRAME_LEN_W-1:0] frame_len_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_RECV,
        W_OVERFLOW
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

    // One beat from the MAC: framing controls plus a 32-bit word whose first
    // byte sits in [31:24]; bytes_valid is 1..4.
    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } eth_rx_bus_t;

    // Number of 32-bit words occupied by a frame of len bytes.
    function automatic logic [9:0] frame_words(input frame_len_t len);
        logic [11:0] sum;
        sum = {1'b0, len} + 12'd3;
        return sum[11:2];
    endfunction

    // Valid byte count of the final word of a frame of len bytes.
    function automatic logic [2:0] last_word_bytes(input frame_len_t len);
        return (len[1:0] == 2'd0) ? 3'd4 : {1'b0, len[1:0]};
    endfunction

endpackage

// File: rtl/eth_rx_len_fifo.sv
// eth_rx_len_fifo: synchronous FIFO holding the byte lengths of committed
// frames. The head entry is readable combinationally; push into a full FIFO
// and pop from an empty FIFO are ignored.
module eth_rx_len_fifo
    import eth_rx_frame_buffer_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  frame_len_t push_len,
    input  logic       pop,
    output frame_len_t head_len,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    frame_len_t    mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_len = mem[rd_ptr_q[AW-1:0]];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Advance the pointers on accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Length storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_len;
    end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// eth_rx_frame_buffer: store-and-forward receive buffer between the MAC and a
// frame reader. Words are written speculatively at wr_spec and become visible
// to the reader only when the frame commits (wr_commit catches up and the
// length is queued). Define ETH_RX_FRAME_BUFFER_STATS_EN to add saturating
// committed/dropped/overflow frame counters.
module eth_rx_frame_buffer
    import eth_rx_frame_buffer_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int MAX_FRAMES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  eth_rx_bus_t rx_bus,
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
    output logic [31:0] stat_frames_committed,
    output logic [31:0] stat_frames_dropped,
    output logic [31:0] stat_frames_overflow,
`endif
    output logic        rd_frame_ready,
    output frame_len_t  rd_frame_len,
    input  logic        rd_start,
    output logic        rd_data_valid,
    output logic [31:0] rd_data,
    output logic [2:0]  rd_bytes_valid,
    output logic        rd_last
);

    localparam int             AW        = $clog2(DEPTH_WORDS);
    localparam int             PW        = AW + 1;
    localparam logic [PW-1:0]  DEPTH_P   = PW'(DEPTH_WORDS);
    localparam logic [11:0]    MAX_BYTES = 12'(MAX_FRAME_BYTES);

    logic [31:0]   mem [DEPTH_WORDS];

    // Write side
    wr_state_t     wr_state_q, wr_state_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [11:0]   byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] wr_used;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;

    // Read side
    rd_state_t     rd_state_q, rd_state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [9:0]    words_left_q, words_left_d;
    logic [2:0]    last_bytes_q, last_bytes_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [2:0]    rd_bv_q, rd_bv_d;
    logic [31:0]   rd_data_q;
    logic          rd_issue;

    // Length queue
    logic          len_push;
    logic          len_pop;
    logic          len_empty;
    logic          len_full;
    frame_len_t    len_head;

    eth_rx_len_fifo #(
        .DEPTH (MAX_FRAMES)
    ) u_len_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (len_push),
        .push_len (byte_cnt_q[FRAME_LEN_W-1:0]),
        .pop      (len_pop),
        .head_len (len_head),
        .empty    (len_empty),
        .full     (len_full)
    );

    assign rd_frame_ready = !len_empty && (rd_state_q == R_IDLE);
    assign rd_frame_len   = rd_frame_ready ? len_head : '0;
    assign rd_data_valid  = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_bytes_valid = rd_bv_q;
    assign rd_last        = rd_last_q;

    // Write FSM: resolve commit/drop first, then start, then accept data
    // against the state that results, so start can share a cycle with either.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        byte_cnt_d  = byte_cnt_q;
        wr_used     = '0;
        len_push    = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_spec_q[AW-1:0];

        if (wr_state_q == W_RECV && rx_bus.commit) begin
            if (byte_cnt_q != 12'd0 && !len_full) begin
                len_push    = 1'b1;
                wr_commit_d = wr_spec_q;
            end else begin
                wr_spec_d = wr_commit_q;
            end
            wr_state_d = W_IDLE;
        end else if (wr_state_q == W_RECV && rx_bus.drop) begin
            wr_spec_d  = wr_commit_q;
            wr_state_d = W_IDLE;
        end else if (wr_state_q == W_OVERFLOW && (rx_bus.commit || rx_bus.drop)) begin
            wr_spec_d  = wr_commit_q;
            wr_state_d = W_IDLE;
        end

        if (rx_bus.start) begin
            wr_spec_d  = wr_commit_d;
            byte_cnt_d = '0;
            wr_state_d = W_RECV;
        end

        if (wr_state_d == W_RECV && rx_bus.data_valid) begin
            wr_used = wr_spec_d - rd_ptr_q;
            if (wr_used < DEPTH_P) begin
                ram_we     = 1'b1;
                ram_waddr  = wr_spec_d[AW-1:0];
                wr_spec_d  = wr_spec_d + PW'(1);
                byte_cnt_d = byte_cnt_d + {9'd0, rx_bus.bytes_valid};
                if (byte_cnt_d > MAX_BYTES) wr_state_d = W_OVERFLOW;
            end else begin
                wr_state_d = W_OVERFLOW;
            end
        end
    end

    // Write FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= W_IDLE;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    // Frame data RAM write port.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= rx_bus.data;
    end

    // Read FSM: pop the head length on rd_start, then issue one RAM read per
    // cycle; the registered RAM output lands two cycles after rd_start.
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_ptr_d     = rd_ptr_q;
        words_left_d = words_left_q;
        last_bytes_d = last_bytes_q;
        len_pop      = 1'b0;
        rd_issue     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        rd_bv_d      = 3'd0;

        case (rd_state_q)
            R_IDLE: begin
                if (rd_start && rd_frame_ready) begin
                    len_pop      = 1'b1;
                    words_left_d = frame_words(len_head);
                    last_bytes_d = last_word_bytes(len_head);
                    rd_state_d   = R_STREAM;
                end
            end
            R_STREAM: begin
                rd_issue     = 1'b1;
                rd_ptr_d     = rd_ptr_q + PW'(1);
                words_left_d = words_left_q - 10'd1;
                rd_valid_d   = 1'b1;
                rd_bv_d      = 3'd4;
                if (words_left_q == 10'd1) begin
                    rd_last_d  = 1'b1;
                    rd_bv_d    = last_bytes_q;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers and registered stream qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q   <= R_IDLE;
            rd_ptr_q     <= '0;
            words_left_q <= '0;
            last_bytes_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_bv_q      <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_ptr_q     <= rd_ptr_d;
            words_left_q <= words_left_d;
            last_bytes_q <= last_bytes_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_bv_q      <= rd_bv_d;
        end
    end

    // Frame data RAM read port, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_issue) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
    logic [31:0] stat_commit_q, stat_commit_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic [31:0] stat_ovf_q, stat_ovf_d;
    logic        ev_drop;
    logic        ev_ovf;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // Classify how each frame leaves the write side; a start that abandons an
    // unfinished frame counts as a drop.
    always_comb begin
        ev_drop = 1'b0;
        ev_ovf  = 1'b0;
        if (wr_state_q == W_RECV) begin
            if (rx_bus.commit)    ev_ovf  = !len_push;
            else if (rx_bus.drop) ev_drop = 1'b1;
        end else if (wr_state_q == W_OVERFLOW) begin
            ev_ovf = rx_bus.commit || rx_bus.drop;
        end
        if (rx_bus.start && wr_state_q != W_IDLE && !rx_bus.commit && !rx_bus.drop) begin
            ev_drop = 1'b1;
        end
        stat_commit_d = sat_inc(stat_commit_q, len_push);
        stat_drop_d   = sat_inc(stat_drop_q, ev_drop);
        stat_ovf_d    = sat_inc(stat_ovf_q, ev_ovf);
    end

    // Statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_commit_q <= '0;
            stat_drop_q   <= '0;
            stat_ovf_q    <= '0;
        end else begin
            stat_commit_q <= stat_commit_d;
            stat_drop_q   <= stat_drop_d;
            stat_ovf_q    <= stat_ovf_d;
        end
    end

    assign stat_frames_committed = stat_commit_q;
    assign stat_frames_dropped   = stat_drop_q;
    assign stat_frames_overflow  = stat_ovf_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Testbench for eth_rx_frame_buffer (DEPTH_WORDS=16, MAX_FRAMES=4). The model
// keeps committed frames as a length queue plus a word queue and decides each
// frame's fate from occupancy, byte count and queue capacity.
module tb_eth_rx_frame_buffer;
    import eth_rx_frame_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int MAXF  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    eth_rx_bus_t rx_bus;
    logic        rd_start;
    logic        rd_frame_ready;
    frame_len_t  rd_frame_len;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic [2:0]  rd_bytes_valid;
    logic        rd_last;
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
    logic [31:0] stat_c, stat_d, stat_o;
`endif

    always #5 clk = ~clk;

    eth_rx_frame_buffer #(
        .DEPTH_WORDS (DEPTH),
        .MAX_FRAMES  (MAXF)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rx_bus                (rx_bus),
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
        .stat_frames_committed (stat_c),
        .stat_frames_dropped   (stat_d),
        .stat_frames_overflow  (stat_o),
`endif
        .rd_frame_ready        (rd_frame_ready),
        .rd_frame_len          (rd_frame_len),
        .rd_start              (rd_start),
        .rd_data_valid         (rd_data_valid),
        .rd_data               (rd_data),
        .rd_bytes_valid        (rd_bytes_valid),
        .rd_last               (rd_last)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mdl_len[$];
    logic [31:0] mdl_words[$];
    logic [31:0] pend[$];
    int          pend_bytes = 0;
    int          m_commit = 0;
    int          m_drop   = 0;
    int          m_ovf    = 0;

    typedef struct {
        int nbytes;
        int act;       // 0 commit, 1 drop
        int exp_ready;
        int exp_len;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        rx_bus.start = 1'b1;
        tick();
        rx_bus.start = 1'b0;
        pend.delete();
        pend_bytes = 0;
    endtask

    task automatic push_bytes(input int n);
        int nw;
        logic [31:0] w;
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            rx_bus.data        = w;
            rx_bus.bytes_valid = (i == nw - 1 && (n % 4) != 0) ? 3'(n % 4) : 3'd4;
            rx_bus.data_valid  = 1'b1;
            tick();
            pend.push_back(w);
        end
        rx_bus.data_valid = 1'b0;
        pend_bytes += n;
    endtask

    // Fate of the pending frame when it is closed by commit (0) or drop (1).
    task automatic model_close(input int act);
        bit ovf;
        ovf = (mdl_words.size() + pend.size()) > DEPTH;
        if (act == 0) begin
            if (ovf) m_ovf++;
            else if (pend_bytes > 0 && mdl_len.size() < MAXF) begin
                mdl_len.push_back(pend_bytes);
                foreach (pend[i]) mdl_words.push_back(pend[i]);
                m_commit++;
            end else m_ovf++;
        end else begin
            if (ovf) m_ovf++;
            else m_drop++;
        end
        pend.delete();
        pend_bytes = 0;
    endtask

    task automatic end_frame(input int act);
        if (act == 0) rx_bus.commit = 1'b1;
        else rx_bus.drop = 1'b1;
        tick();
        rx_bus.commit = 1'b0;
        rx_bus.drop   = 1'b0;
        model_close(act);
    endtask

    task automatic read_frame();
        int len, nw;
        logic [31:0] w;
        if (mdl_len.size() == 0) begin
            check("ready_when_empty", 32'(rd_frame_ready), 32'd0);
            return;
        end
        len = mdl_len.pop_front();
        check("rd_frame_ready", 32'(rd_frame_ready), 32'd1);
        check("rd_frame_len", 32'(rd_frame_len), 32'(len));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("valid_at_n_plus_1", 32'(rd_data_valid), 32'd0);
        check("ready_while_stream", 32'(rd_frame_ready), 32'd0);
        nw = (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            tick();
            w = mdl_words.pop_front();
            check("rd_data_valid", 32'(rd_data_valid), 32'd1);
            check("rd_data", rd_data, w);
            check("rd_bytes_valid", 32'(rd_bytes_valid),
                  (i == nw - 1 && (len % 4) != 0) ? 32'(len % 4) : 32'd4);
            check("rd_last", 32'(rd_last), (i == nw - 1) ? 32'd1 : 32'd0);
        end
        tick();
        check("valid_after_last", 32'(rd_data_valid), 32'd0);
    endtask

    task automatic drain();
        while (mdl_len.size() > 0) read_frame();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(rd_frame_ready), 32'd0);
        check({tag, "_valid"}, 32'(rd_data_valid), 32'd0);
        check({tag, "_len"}, 32'(rd_frame_len), 32'd0);
        check({tag, "_bv"}, 32'(rd_bytes_valid), 32'd0);
        check({tag, "_last"}, 32'(rd_last), 32'd0);
        check({tag, "_data"}, rd_data, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int r, n, a;
        tbl = '{
            '{64, 0, 1, 64}, '{61, 0, 1, 61}, '{1, 0, 1, 1}, '{4, 0, 1, 4},
            '{5, 0, 1, 5},   '{30, 1, 0, 0},  '{80, 0, 0, 0}, '{40, 0, 1, 40},
            '{0, 0, 0, 0},   '{63, 0, 1, 63}
        };
        rx_bus   = '0;
        rd_start = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Table: each frame written into an empty buffer, then read back.
        for (int i = 0; i < 10; i++) begin
            begin_frame();
            push_bytes(tbl[i].nbytes);
            end_frame(tbl[i].act);
            tick();
            check("tbl_ready", 32'(rd_frame_ready), 32'(tbl[i].exp_ready));
            check("tbl_len", 32'(rd_frame_len), 32'(tbl[i].exp_len));
            drain();
        end

        // Committed, dropped, committed: only the first and last are read.
        begin_frame(); push_bytes(24); end_frame(0);
        begin_frame(); push_bytes(36); end_frame(1);
        begin_frame(); push_bytes(12); end_frame(0);
        check("abc_first_len", 32'(rd_frame_len), 32'd24);
        read_frame();
        check("abc_second_len", 32'(rd_frame_len), 32'd12);
        read_frame();
        check("abc_empty", 32'(rd_frame_ready), 32'd0);

        // Restart mid-frame without commit, then a 20-byte frame.
        begin_frame(); push_bytes(12);
        begin_frame(); m_drop++;
        push_bytes(20); end_frame(0);
        check("restart_len", 32'(rd_frame_len), 32'd20);
        read_frame();
        check("restart_single", 32'(rd_frame_ready), 32'd0);

        // Commit and start in the same cycle.
        begin_frame(); push_bytes(8);
        rx_bus.commit = 1'b1;
        rx_bus.start  = 1'b1;
        tick();
        rx_bus.commit = 1'b0;
        rx_bus.start  = 1'b0;
        model_close(0);
        push_bytes(12); end_frame(0);
        check("startcommit_len", 32'(rd_frame_len), 32'd8);
        drain();

        // Length queue full: the fifth commit rolls back.
        for (int i = 0; i < 5; i++) begin
            begin_frame(); push_bytes(4); end_frame(0);
        end
        drain();
        check("qfull_empty", 32'(rd_frame_ready), 32'd0);

        // Full buffer streamed out while the next frame is written into freed space.
        begin_frame(); push_bytes(64); end_frame(0);
        fork
            read_frame();
            begin
                repeat (4) tick();
                begin_frame(); push_bytes(40); end_frame(0);
            end
        join
        check("concurrent_len", 32'(rd_frame_len), 32'd40);
        drain();

`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
        check("stat_committed", stat_c, 32'(m_commit));
        check("stat_dropped", stat_d, 32'(m_drop));
        check("stat_overflow", stat_o, 32'(m_ovf));
`endif

        // Reset while one frame streams and two more are queued.
        for (int i = 0; i < 3; i++) begin
            begin_frame(); push_bytes(8); end_frame(0);
        end
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        check("pre_reset_valid", 32'(rd_data_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(rd_frame_ready), 32'd0);
        mdl_len.delete();
        mdl_words.delete();
        m_commit = 0; m_drop = 0; m_ovf = 0;

        // Randomized mix of writes, drops, restarts and reads.
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3 && mdl_len.size() > 0) begin
                read_frame();
            end else begin
                n = $urandom_range(1, 70);
                begin_frame();
                push_bytes(n);
                a = $urandom_range(0, 9);
                if (a < 7) end_frame(0);
                else if (a < 8) end_frame(1);
                else begin
                    begin_frame();
                    m_drop++;
                    rx_bus.drop = 1'b1;
                    tick();
                    rx_bus.drop = 1'b0;
                    m_drop++;
                end
            end
            check("rand_ready", 32'(rd_frame_ready), (mdl_len.size() > 0) ? 32'd1 : 32'd0);
            check("rand_len", 32'(rd_frame_len), (mdl_len.size() > 0) ? 32'(mdl_len[0]) : 32'd0);
        end
        drain();

`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
        check("rand_stat_committed", stat_c, 32'(m_commit));
        check("rand_stat_dropped", stat_d, 32'(m_drop));
        check("rand_stat_overflow", stat_o, 32'(m_ovf));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_buffer.md
ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, data-RAM depth in 32-bit words, power of two.
REQ-002 Parameter MAX_FRAMES, default 32, committed-frame length-queue depth, power of two.
REQ-003 clk  in  1  single clock for all logic (MAC RX clock domain).
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_bus  in  EthernetRxBus  start/data_valid/bytes_valid/data/commit/drop from the MAC.
REQ-006 rd_frame_ready  out  1  at least one committed frame queued and reader idle.
REQ-007 rd_frame_len  out  11  byte length of the head frame, valid while rd_frame_ready.
REQ-008 rd_start  in  1  pulse to begin streaming the head frame.
REQ-009 rd_data_valid  out  1  rd_data holds a frame word.
REQ-010 rd_data  out  32  frame word, first byte in [31:24].
REQ-011 rd_bytes_valid  out  3  valid bytes in rd_data (1..4).
REQ-012 rd_last  out  1  final word of the frame.

Function
REQ-013 Write FSM states W_IDLE, W_RECV, W_OVERFLOW; read FSM states R_IDLE, R_STREAM.
REQ-014 Write pointers: wr_commit (visible) and wr_spec (speculative), each log2(DEPTH_WORDS)+1 bits for wrap detection.
REQ-015 rx_bus.start in any write state: wr_spec <= wr_commit, byte count <= 0, state W_RECV; an uncommitted frame in progress is discarded.
REQ-016 W_RECV data_valid: if (wr_spec - rd_ptr) < DEPTH_WORDS, write data at wr_spec and increment it, add bytes_valid to byte count; otherwise state W_OVERFLOW.
REQ-017 Byte count exceeding 2047 moves to W_OVERFLOW.
REQ-018 W_RECV commit: if byte count > 0 and length queue not full, push count and set wr_commit <= wr_spec; else roll back; state W_IDLE.
REQ-019 W_RECV drop: wr_spec <= wr_commit, state W_IDLE.
REQ-020 W_OVERFLOW: ignore data; commit or drop rolls back wr_spec, state W_IDLE.
REQ-021 start and commit/drop in one cycle: commit/drop resolves first, then start.
REQ-022 rd_frame_ready = length queue non-empty and R_IDLE; rd_frame_len shows queue head.
REQ-023 rd_start when rd_frame_ready: pop queue, state R_STREAM; rd_start otherwise ignored.
REQ-024 First rd_data_valid two cycles after rd_start; one word per cycle, no gaps, no backpressure.
REQ-025 Words streamed = ceil(len/4); final word rd_last=1, rd_bytes_valid = len mod 4 or 4 if zero; others 4.
REQ-026 rd_ptr increments per word read; freed space visible to writer next cycle.
REQ-027 Simultaneous write and read always allowed; full = (wr_spec - rd_ptr) == DEPTH_WORDS.

Reset
REQ-028 rst_n low: all pointers 0, length queue empty, W_IDLE, R_IDLE, all outputs 0, counters 0.
REQ-029 Reset mid-frame discards all buffered and in-progress frames; RAM contents need not clear.

Configuration
REQ-030 With ETH_RX_FRAME_BUFFER_STATS_EN defined, outputs stat_frames_committed, stat_frames_dropped, stat_frames_overflow (32 bits each, saturating) exist and count REQ-018 commits, REQ-019/REQ-015 discards, REQ-020/REQ-018-rollback events.
REQ-031 Without the macro, those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package holds the frame-length type (11 bits), max-frame-byte constant 2047, FSM enums.
REQ-033 One sub-module: eth_rx_len_fifo (MAX_FRAMES x 11-bit synchronous FIFO); data RAM is inferred inline.

Verification
REQ-034 64-byte frame, commit -> rd_frame_len=64; 16 words, rd_last on word 16, rd_bytes_valid=4.
REQ-035 61-byte frame, commit, rd_start at cycle N -> first word N+2, 16 words, last rd_bytes_valid=1.
REQ-036 Frame A committed, frame B dropped, frame C committed -> only A then C read, lengths intact.
REQ-037 DEPTH_WORDS=16, 80-byte frame -> overflow, nothing queued, stat_frames_overflow=1; next 40-byte frame reads correctly.
REQ-038 start mid-frame without commit, then 20-byte frame committed -> single frame of 20 bytes queued.
REQ-039 rst_n asserted with 2 frames queued and one streaming -> rd_frame_ready=0, rd_data_valid=0 immediately.
